ring_sequencer: RTL
===================

RING_SEQUENCER -- requirements
Module: ring_sequencer

Interface
REQ-001 Parameter N_STATES, default 6, number of T-states per instruction cycle; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, width of the instruction-cycle counter.
REQ-003 Port clk  input  1  system clock; every register updates on the falling edge of clk (the active edge).
REQ-004 Port res  input  1  synchronous active-high reset, sampled on the active edge.
REQ-005 Port en  input  1  advance enable; low holds all state.
REQ-006 Port done  input  1  early end: the current T-state is the last one of this instruction.
REQ-007 Port hlt  input  1  halt request.
REQ-008 Port step_mode  input  1  high selects single-step operation.
REQ-009 Port step  input  1  single-step request, level signal; only its rising transition is used.
REQ-010 Port t  output  N_STATES  one-hot T-state; T1 is t[N_STATES-1], Tlast is t[0].
REQ-011 Port t_idx  output  clog2(N_STATES)  binary T-state index; 0 means T1.
REQ-012 Port last  output  1  combinational; high when t_idx equals N_STATES-1.
REQ-013 Port halted  output  1  registered halt flag.
REQ-014 Port icount  output  CNT_W  completed-instruction count.

Function
REQ-015 The step pulse shall be high for one active edge when step is 1 and the previously sampled step is 0.
REQ-016 The advance condition shall be en AND NOT halted AND NOT hlt AND (NOT step_mode OR step pulse).
REQ-017 On advance, if last or done is high, then t shall become T1, t_idx shall become 0, and icount shall increment modulo 2^CNT_W.
REQ-018 On advance otherwise, t shall shift right by one position and t_idx shall increment by 1.
REQ-019 Without advance, t, t_idx and icount shall hold.
REQ-020 hlt sampled high shall set halted and freeze t, t_idx and icount at the same edge; hlt takes priority over advance.
REQ-021 halted shall clear only on res; deasserting hlt shall not resume operation.
REQ-022 done asserted in T1 shall return to T1 on advance and increment icount (a one-state instruction).
REQ-023 done or last without advance shall have no effect.
REQ-024 If t is ever not one-hot, the next active edge shall load T1 and t_idx 0, regardless of en, and icount shall not change.
REQ-025 A change of step_mode shall take effect at the next active edge; a step pulse while step_mode is 0 shall be ignored.
REQ-026 t and t_idx shall always be consistent after every edge.

Reset
REQ-027 res high at an active edge shall set t to T1 (MSB only), t_idx to 0, icount to 0, halted to 0 and the step history to 0.
REQ-028 res shall override en, hlt, done and step at the same edge, including mid-instruction and while halted.
REQ-029 Between power-up and the first res, t shall initialise to T1 and all other registers to 0.

Structure
REQ-030 Shared package sap_pkg shall hold N_STATES_DEF = 6, CNT_W_DEF = 8, the T1 index constant and a clog2 function.
REQ-031 Rising-edge detection of step shall be the sub-module edge_detect (ports clk, res, d, pulse), instantiated once.
REQ-032 The one-hot register, index register, counter and halt flag shall live in ring_sequencer.

Verification
REQ-033 Reset, then en=1 for 12 edges with N_STATES=6 -> t: 100000, 010000, ..., 000001, 100000, ...; icount=2; last high at t=000001.
REQ-034 done=1 during T3 (t=001000) -> next edge t=100000, t_idx=0, icount increments by 1.
REQ-035 hlt=1 at T4 -> t stays 000100 and halted=1 for 10 edges after hlt drops; res -> t=100000, halted=0, icount=0.
REQ-036 step_mode=1 with step held high for 5 edges -> exactly one advance; a second 0->1 transition of step -> one more advance.
REQ-037 Forced t=000110 -> next edge t=100000, t_idx=0, icount unchanged; repeat with N_STATES=2, 10 edges -> alternating 10/01, icount=5.
REQ-038 res and hlt high together at T5 -> t=100000, halted=0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and helpers for the SAP-style instruction sequencer.
package sap_pkg;
  localparam int N_STATES_DEF = 6;
  localparam int CNT_W_DEF    = 8;
  localparam int T1_IDX       = 0;

  // Index width for a count of states; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// Rising-transition detector for a level input, evaluated on the falling clock edge.
module edge_detect (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic pulse
);
  logic prev_q = 1'b0;

  always_ff @(negedge clk) begin
    if (res) prev_q <= 1'b0;
    else     prev_q <= d;
  end

  assign pulse = d & ~prev_q;
endmodule

// File: rtl/ring_sequencer.sv
// One-hot T-state ring with binary index, completed-instruction counter,
// sticky halt and optional single-step gating; all state moves on the falling edge.
module ring_sequencer
  import sap_pkg::*;
#(
  parameter  int N_STATES = N_STATES_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int IDX_W    = clog2(N_STATES)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                en,
  input  logic                done,
  input  logic                hlt,
  input  logic                step_mode,
  input  logic                step,
  output logic [N_STATES-1:0] t,
  output logic [IDX_W-1:0]    t_idx,
  output logic                last,
  output logic                halted,
  output logic [CNT_W-1:0]    icount
);
  localparam logic [N_STATES-1:0] T1_VEC   = {1'b1, {(N_STATES-1){1'b0}}};
  localparam logic [N_STATES-1:0] ONE_VEC  = {{(N_STATES-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]    T1_I     = IDX_W'(T1_IDX);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_STATES - 1);

  logic [N_STATES-1:0] t_q      = T1_VEC;
  logic [IDX_W-1:0]    idx_q    = '0;
  logic [CNT_W-1:0]    cnt_q    = '0;
  logic                halted_q = 1'b0;

  logic [N_STATES-1:0] t_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                step_pulse;
  logic                ring_ok;
  logic                advance;

  edge_detect u_step_edge (
    .clk   (clk),
    .res   (res),
    .d     (step),
    .pulse (step_pulse)
  );

  assign last = (idx_q == LAST_IDX);

  // Next-state: a corrupted ring always recovers to T1 without counting an instruction.
  always_comb begin
    ring_ok = (t_q != '0) && ((t_q & (t_q - ONE_VEC)) == '0);
    advance = en && !halted_q && !hlt && (!step_mode || step_pulse);
    t_nxt   = t_q;
    idx_nxt = idx_q;
    cnt_nxt = cnt_q;
    if (!ring_ok) begin
      t_nxt   = T1_VEC;
      idx_nxt = T1_I;
    end else if (advance) begin
      if (last || done) begin
        t_nxt   = T1_VEC;
        idx_nxt = T1_I;
        cnt_nxt = cnt_q + CNT_W'(1);
      end else begin
        t_nxt   = t_q >> 1;
        idx_nxt = idx_q + IDX_W'(1);
      end
    end
  end

  // State register
  always_ff @(negedge clk) begin
    if (res) begin
      t_q      <= T1_VEC;
      idx_q    <= T1_I;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_nxt;
      idx_q    <= idx_nxt;
      cnt_q    <= cnt_nxt;
      halted_q <= halted_q | hlt;
    end
  end

  // Outputs
  always_comb begin
    t      = t_q;
    t_idx  = idx_q;
    icount = cnt_q;
    halted = halted_q;
  end
endmodule
